// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM sequencer slice.
// Holds the default network dimensions, the sequencer state encoding and
// a helper that turns an entry count into an address width of at least 1 bit.
package rbm_pkg;

  localparam int N_VIS_DEF = 784;
  localparam int N_HID_DEF = 441;
  localparam int N_CLS_DEF = 10;
  localparam int W_DEF     = 12;
  localparam int ITER_DEF  = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_CLS  = 2'd2,
    ST_DONE = 2'd3
  } rbm_state_e;

  // Address width for a memory of n entries; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int VIS_AW_DEF = addr_w(N_VIS_DEF);
  localparam int HID_AW_DEF = addr_w(N_HID_DEF + 1);
  localparam int CLS_AW_DEF = addr_w(N_CLS_DEF);

endpackage

// File: rtl/rbm_spike_counter_bank.sv
// Per-class spike counters.
// Ports: clock/reset (sync, active-high); clear_i zeroes every counter;
// inc_i adds one to counter idx_i; count_o is the combinational value of
// counter sel_i.
module rbm_spike_counter_bank
  import rbm_pkg::*;
#(
  parameter int N_CLS = N_CLS_DEF,
  parameter int CNT_W = 7,
  localparam int CAW  = addr_w(N_CLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [CAW-1:0]   idx_i,
  input  logic [CAW-1:0]   sel_i,
  output logic [CNT_W-1:0] count_o
);

  logic [N_CLS-1:0][CNT_W-1:0] cnt_q;
  logic [N_CLS-1:0][CNT_W-1:0] cnt_d;

  // Next counter values: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      for (int i = 0; i < N_CLS; i++) begin
        if (idx_i == CAW'(i)) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Readback mux.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < N_CLS; i++) begin
      count_o = count_o | (cnt_q[i] & {CNT_W{sel_i == CAW'(i)}});
    end
  end

endmodule

// File: rtl/rbm_sequencer.sv
// Sequencer that drives the RBM Main engine.
// Streams image pixels and hidden weights/biases neuron by neuron (HID),
// latches each hidden result into hbuf, then streams hbuf and classifier
// weights/biases class by class (CLS), counting spikes per class, for ITER
// iterations. Ports: clock/reset (sync, active-high), start/busy/done
// handshake, combinational memory read ports (img_*, hw_*, hsw_data, cw_*),
// engine beat outputs eng_*, engine results eng_hidden/eng_spike, and
// count_sel/count_out spike-count readback.
module rbm_sequencer
  import rbm_pkg::*;
#(
  parameter int N_VIS = N_VIS_DEF,
  parameter int N_HID = N_HID_DEF,
  parameter int N_CLS = N_CLS_DEF,
  parameter int W     = W_DEF,
  parameter int ITER  = ITER_DEF,
  parameter int CNT_W = $clog2(ITER + 1),
  localparam int VAW  = addr_w(N_VIS),
  localparam int HAW  = addr_w(N_HID + 1),
  localparam int CAW  = addr_w(N_CLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [VAW-1:0]   img_addr,
  input  logic             img_data,
  output logic [VAW-1:0]   hw_addr_v,
  output logic [HAW-1:0]   hw_addr_h,
  input  logic [W-1:0]     hw_data,
  input  logic             hsw_data,
  output logic [HAW-1:0]   cw_addr_h,
  output logic [CAW-1:0]   cw_addr_c,
  input  logic [W-1:0]     cw_data,
  output logic [W-1:0]     eng_hvalue,
  output logic [9:0]       eng_pixel_id,
  output logic             eng_pixel,
  output logic             eng_switch,
  output logic             eng_en_hid,
  output logic             eng_en_cls,
  output logic [W-1:0]     eng_cvalue,
  output logic [8:0]       eng_hidden_id,
  output logic             eng_hidden_pixel,
  input  logic             eng_hidden,
  input  logic             eng_spike,
  input  logic [CAW-1:0]   count_sel,
  output logic [CNT_W-1:0] count_out
);

  localparam int VIW = $clog2(N_VIS + 1);  // beat index includes the bias beat
  localparam int CIW = $clog2(N_CLS + 1);  // class index N_CLS marks the gap cycle
  localparam int IW  = addr_w(ITER);

  rbm_state_e       st_q, st_d;
  logic [VIW-1:0]   v_q, v_d;
  logic [HAW-1:0]   h_q, h_d;
  logic [HAW-1:0]   k_q, k_d;
  logic [CIW-1:0]   c_q, c_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             hsamp_q, hsamp_d;
  logic [HAW-1:0]   hidx_q, hidx_d;
  logic             csamp_q, csamp_d;
  logic [CAW-1:0]   cidx_q, cidx_d;
  logic [N_HID-1:0] hbuf_q, hbuf_d;
  logic             clr_s;
  logic             hbuf_rd_s;

  // Next-state logic. A sample flag marks the cycle after a bias beat; that
  // cycle already carries beat 0 of the following neuron or class.
  always_comb begin
    st_d    = st_q;
    v_d     = v_q;
    h_d     = h_q;
    k_d     = k_q;
    c_d     = c_q;
    iter_d  = iter_q;
    hidx_d  = hidx_q;
    cidx_d  = cidx_q;
    hsamp_d = 1'b0;
    csamp_d = 1'b0;
    clr_s   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (start) begin
          st_d   = ST_HID;
          v_d    = '0;
          h_d    = '0;
          k_d    = '0;
          c_d    = '0;
          iter_d = '0;
          clr_s  = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      ST_HID: begin
        if (v_q == VIW'(N_VIS)) begin
          hsamp_d = 1'b1;
          hidx_d  = h_q;
          v_d     = '0;
          if (h_q == HAW'(N_HID - 1)) begin
            st_d = ST_CLS;
            h_d  = '0;
            k_d  = '0;
            c_d  = '0;
          end else begin
            h_d = h_q + HAW'(1);
          end
        end else begin
          v_d = v_q + VIW'(1);
        end
      end
      ST_CLS: begin
        if (c_q == CIW'(N_CLS)) begin
          // Gap cycle between iterations: only the last class sample happens.
          st_d   = ST_HID;
          v_d    = '0;
          h_d    = '0;
          c_d    = '0;
          iter_d = iter_q + IW'(1);
        end else if (k_q == HAW'(N_HID)) begin
          csamp_d = 1'b1;
          cidx_d  = c_q[CAW-1:0];
          k_d     = '0;
          if (c_q == CIW'(N_CLS - 1)) begin
            if (iter_q == IW'(ITER - 1)) begin
              st_d = ST_DONE;
            end else begin
              c_d = CIW'(N_CLS);
            end
          end else begin
            c_d = c_q + CIW'(1);
          end
        end else begin
          k_d = k_q + HAW'(1);
        end
      end
      ST_DONE: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  // Hidden buffer update: cleared on start, one bit written per sample cycle.
  always_comb begin
    hbuf_d = hbuf_q;
    if (clr_s) begin
      hbuf_d = '0;
    end else begin
      for (int i = 0; i < N_HID; i++) begin
        if (hsamp_q && (hidx_q == HAW'(i))) begin
          hbuf_d[i] = eng_hidden;
        end else begin
          hbuf_d[i] = hbuf_q[i];
        end
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q    <= ST_IDLE;
      v_q     <= '0;
      h_q     <= '0;
      k_q     <= '0;
      c_q     <= '0;
      iter_q  <= '0;
      hsamp_q <= 1'b0;
      hidx_q  <= '0;
      csamp_q <= 1'b0;
      cidx_q  <= '0;
      hbuf_q  <= '0;
    end else begin
      st_q    <= st_d;
      v_q     <= v_d;
      h_q     <= h_d;
      k_q     <= k_d;
      c_q     <= c_d;
      iter_q  <= iter_d;
      hsamp_q <= hsamp_d;
      hidx_q  <= hidx_d;
      csamp_q <= csamp_d;
      cidx_q  <= cidx_d;
      hbuf_q  <= hbuf_d;
    end
  end

  // hbuf read for CLS beat k; forwards a bit still being written this cycle
  // (only reachable with a single hidden neuron).
  always_comb begin
    hbuf_rd_s = 1'b0;
    for (int i = 0; i < N_HID; i++) begin
      hbuf_rd_s = hbuf_rd_s | (hbuf_q[i] & (k_q == HAW'(i)));
    end
    if (hsamp_q && (hidx_q == k_q)) begin
      hbuf_rd_s = eng_hidden;
    end else begin
      hbuf_rd_s = hbuf_rd_s;
    end
  end

  // Engine beat and memory address outputs; everything idles at 0.
  always_comb begin
    img_addr         = '0;
    hw_addr_v        = '0;
    hw_addr_h        = '0;
    cw_addr_h        = '0;
    cw_addr_c        = '0;
    eng_hvalue       = '0;
    eng_pixel_id     = '0;
    eng_pixel        = 1'b0;
    eng_switch       = 1'b0;
    eng_en_hid       = 1'b0;
    eng_en_cls       = 1'b0;
    eng_cvalue       = '0;
    eng_hidden_id    = '0;
    eng_hidden_pixel = 1'b0;
    case (st_q)
      ST_HID: begin
        eng_en_hid   = 1'b1;
        hw_addr_h    = h_q;
        eng_hvalue   = hw_data;
        eng_switch   = hsw_data;
        eng_pixel_id = 10'(v_q);
        if (v_q == VIW'(N_VIS)) begin
          eng_pixel = 1'b1;
        end else begin
          img_addr  = v_q[VAW-1:0];
          hw_addr_v = v_q[VAW-1:0];
          eng_pixel = img_data;
        end
      end
      ST_CLS: begin
        if (c_q != CIW'(N_CLS)) begin
          eng_en_cls    = 1'b1;
          cw_addr_h     = k_q;
          cw_addr_c     = c_q[CAW-1:0];
          eng_cvalue    = cw_data;
          eng_hidden_id = 9'(k_q);
          eng_hidden_pixel = (k_q == HAW'(N_HID)) ? 1'b1 : hbuf_rd_s;
        end else begin
          eng_en_cls = 1'b0;
        end
      end
      default: begin
        eng_en_hid = 1'b0;
      end
    endcase
  end

  assign busy = (st_q != ST_IDLE);
  assign done = (st_q == ST_DONE);

  rbm_spike_counter_bank #(
    .N_CLS (N_CLS),
    .CNT_W (CNT_W)
  ) u_counts (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clr_s),
    .inc_i   (csamp_q & eng_spike),
    .idx_i   (cidx_q),
    .sel_i   (count_sel),
    .count_o (count_out)
  );

endmodule

// File: tb/tb_rbm_sequencer.sv
// Directed bench for rbm_sequencer in the small configuration
// N_VIS=4, N_HID=3, N_CLS=2, ITER=2 (iteration length 24 cycles).
// A stub engine answers eng_hidden = h[0] and eng_spike = 1 for class 1.
module tb_rbm_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  img_addr;
  logic        img_data;
  logic [1:0]  hw_addr_v;
  logic [1:0]  hw_addr_h;
  logic [11:0] hw_data;
  logic        hsw_data;
  logic [1:0]  cw_addr_h;
  logic [0:0]  cw_addr_c;
  logic [11:0] cw_data;
  logic [11:0] eng_hvalue;
  logic [9:0]  eng_pixel_id;
  logic        eng_pixel;
  logic        eng_switch;
  logic        eng_en_hid;
  logic        eng_en_cls;
  logic [11:0] eng_cvalue;
  logic [8:0]  eng_hidden_id;
  logic        eng_hidden_pixel;
  logic        eng_hidden;
  logic        eng_spike;
  logic [0:0]  count_sel;
  logic [1:0]  count_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic mon_en = 1'b0;

  logic [3:0] img_bits = 4'b0110;
  logic [3:0] hsw_bits = 4'b0101;
  logic [1:0] stub_h = 2'd0;
  logic       stub_c = 1'b0;
  logic [1:0] cnt_v;

  always #5 clock = ~clock;

  // Memory models: data encodes the address so passthrough is visible.
  assign img_data = img_bits[img_addr];
  assign hsw_data = hsw_bits[hw_addr_h];
  assign hw_data  = {4'h8, 2'd0, hw_addr_h, 2'd0, hw_addr_v};
  assign cw_data  = {4'hC, 3'd0, cw_addr_h, 2'd0, cw_addr_c};

  // Stub engine: remembers which neuron/class just finished its bias beat.
  always @(posedge clock) begin
    if (eng_en_hid && (eng_pixel_id == 10'd4)) stub_h <= hw_addr_h;
    if (eng_en_cls && (eng_hidden_id == 9'd3)) stub_c <= cw_addr_c[0];
  end
  assign eng_hidden = stub_h[0];
  assign eng_spike  = (stub_c == 1'b1);

  rbm_sequencer #(
    .N_VIS (4),
    .N_HID (3),
    .N_CLS (2),
    .W     (12),
    .ITER  (2)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .img_addr         (img_addr),
    .img_data         (img_data),
    .hw_addr_v        (hw_addr_v),
    .hw_addr_h        (hw_addr_h),
    .hw_data          (hw_data),
    .hsw_data         (hsw_data),
    .cw_addr_h        (cw_addr_h),
    .cw_addr_c        (cw_addr_c),
    .cw_data          (cw_data),
    .eng_hvalue       (eng_hvalue),
    .eng_pixel_id     (eng_pixel_id),
    .eng_pixel        (eng_pixel),
    .eng_switch       (eng_switch),
    .eng_en_hid       (eng_en_hid),
    .eng_en_cls       (eng_en_cls),
    .eng_cvalue       (eng_cvalue),
    .eng_hidden_id    (eng_hidden_id),
    .eng_hidden_pixel (eng_hidden_pixel),
    .eng_hidden       (eng_hidden),
    .eng_spike        (eng_spike),
    .count_sel        (count_sel),
    .count_out        (count_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic read_count(input logic sel, output logic [1:0] val);
    count_sel = sel;
    #1;
    val = count_out;
  endtask

  // Enables must never overlap; also count done pulses.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done === 1'b1) done_cnt++;
      checks++;
      assert (!(eng_en_hid && eng_en_cls)) else begin
        errors++;
        $error("FAIL en_overlap observed=1 expected=0");
      end
    end
  end

  // Full run starting at cycle 0; checks beat timing, hbuf contents, done, counts.
  task automatic full_run(input string tag, input bit extra_start);
    int d0;
    d0 = done_cnt;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_c1_en_hid"}, 32'(eng_en_hid), 32'd1);
    chk({tag, "_c1_pid"}, 32'(eng_pixel_id), 32'd0);
    chk({tag, "_c1_busy"}, 32'(busy), 32'd1);
    if (extra_start) begin
      run_to(7);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    run_to(15);
    chk({tag, "_c15_en_hid"}, 32'(eng_en_hid), 32'd1);
    chk({tag, "_c15_pid"}, 32'(eng_pixel_id), 32'd4);
    chk({tag, "_c15_addr_h"}, 32'(hw_addr_h), 32'd2);
    run_to(16);
    chk({tag, "_c16_en_cls"}, 32'(eng_en_cls), 32'd1);
    chk({tag, "_c16_en_hid"}, 32'(eng_en_hid), 32'd0);
    run_to(24);
    chk({tag, "_c24_en_cls"}, 32'(eng_en_cls), 32'd0);
    chk({tag, "_c24_en_hid"}, 32'(eng_en_hid), 32'd0);
    run_to(25);
    chk({tag, "_c25_en_hid"}, 32'(eng_en_hid), 32'd1);
    chk({tag, "_c25_pid"}, 32'(eng_pixel_id), 32'd0);
    if (extra_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    run_to(47);
    chk({tag, "_c47_done"}, 32'(done), 32'd0);
    run_to(48);
    chk({tag, "_c48_done"}, 32'(done), 32'd1);
    run_to(49);
    chk({tag, "_c49_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    read_count(1'b0, cnt_v);
    chk({tag, "_count0"}, 32'(cnt_v), 32'd0);
    read_count(1'b1, cnt_v);
    chk({tag, "_count1"}, 32'(cnt_v), 32'd2);
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    start = 1'b0;
    count_sel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en_hid", 32'(eng_en_hid), 32'd0);
    chk("rst_en_cls", 32'(eng_en_cls), 32'd0);
    chk("rst_addr_h", 32'(hw_addr_h), 32'd0);
    chk("rst_hvalue", 32'(eng_hvalue), 32'd0);
    read_count(1'b1, cnt_v);
    chk("rst_count1", 32'(cnt_v), 32'd0);

    // Run 1 with detailed beat checks.
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("r1_c1_en_hid", 32'(eng_en_hid), 32'd1);
    chk("r1_c1_pixel", 32'(eng_pixel), 32'(img_bits[0]));
    run_to(2);
    chk("r1_c2_pixel", 32'(eng_pixel), 32'd1);
    run_to(3);
    chk("r1_c3_hvalue", 32'(eng_hvalue), 32'h802);
    chk("r1_c3_pid", 32'(eng_pixel_id), 32'd2);
    run_to(5);
    chk("r1_c5_bias_pid", 32'(eng_pixel_id), 32'd4);
    chk("r1_c5_bias_pixel", 32'(eng_pixel), 32'd1);
    run_to(6);
    chk("r1_c6_pid", 32'(eng_pixel_id), 32'd0);
    chk("r1_c6_addr_h", 32'(hw_addr_h), 32'd1);
    run_to(8);
    chk("r1_c8_hvalue", 32'(eng_hvalue), 32'h812);
    run_to(10);
    chk("r1_c10_switch", 32'(eng_switch), 32'd0);
    run_to(15);
    chk("r1_c15_addr_h", 32'(hw_addr_h), 32'd2);
    chk("r1_c15_pixel", 32'(eng_pixel), 32'd1);
    chk("r1_c15_pid", 32'(eng_pixel_id), 32'd4);
    chk("r1_c15_switch", 32'(eng_switch), 32'd1);
    run_to(16);
    chk("r1_c16_en_cls", 32'(eng_en_cls), 32'd1);
    chk("r1_c16_hbuf0", 32'(eng_hidden_pixel), 32'd0);
    chk("r1_c16_hid", 32'(eng_hidden_id), 32'd0);
    run_to(17);
    chk("r1_c17_hbuf1", 32'(eng_hidden_pixel), 32'd1);
    run_to(18);
    chk("r1_c18_hbuf2", 32'(eng_hidden_pixel), 32'd0);
    run_to(19);
    chk("r1_c19_bias_hp", 32'(eng_hidden_pixel), 32'd1);
    chk("r1_c19_bias_hid", 32'(eng_hidden_id), 32'd3);
    run_to(20);
    chk("r1_c20_cls", 32'(cw_addr_c), 32'd1);
    run_to(21);
    chk("r1_c21_cvalue", 32'(eng_cvalue), 32'hC09);
    run_to(24);
    chk("r1_c24_en_cls", 32'(eng_en_cls), 32'd0);
    chk("r1_c24_busy", 32'(busy), 32'd1);
    run_to(25);
    chk("r1_c25_en_hid", 32'(eng_en_hid), 32'd1);
    run_to(48);
    chk("r1_c48_done", 32'(done), 32'd1);
    run_to(49);
    chk("r1_c49_done", 32'(done), 32'd0);
    read_count(1'b0, cnt_v);
    chk("r1_count0", 32'(cnt_v), 32'd0);
    read_count(1'b1, cnt_v);
    chk("r1_count1", 32'(cnt_v), 32'd2);

    // Reset in the middle of a run.
    d0 = done_cnt;
    cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_en_hid", 32'(eng_en_hid), 32'd0);
    chk("mrst_pid", 32'(eng_pixel_id), 32'd0);
    chk("mrst_addr_h", 32'(hw_addr_h), 32'd0);
    chk("mrst_img_addr", 32'(img_addr), 32'd0);
    read_count(1'b1, cnt_v);
    chk("mrst_count1", 32'(cnt_v), 32'd0);
    run_to(60);
    chk("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    // Clean restart after reset, then a run with start pulses while busy.
    full_run("r2", 1'b0);
    tick();
    full_run("r3", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
